// File: rtl/riscv_wb.sv
// ============================================================================
// Module   : riscv_wb
// Purpose  : RISC-V write-back stage: load alignment, register-file write and
//            data-access fault detection with bus-response stall control.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;
  localparam int EXCEPTION_SIZE           = 16;
  localparam int CAUSE_LOAD_ACCESS_FAULT  = 5;
  localparam int CAUSE_STORE_ACCESS_FAULT = 7;
endpackage

module riscv_wb
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] PC_INIT      = 'h200,
  parameter int              DMEM_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           mem_pc,
  input  logic [XLEN-1:0]           mem_instr,
  input  logic                      mem_bubble,
  input  logic [EXCEPTION_SIZE-1:0] mem_exception,
  input  logic [XLEN-1:0]           mem_r,
  input  logic [XLEN-1:0]           mem_memadr,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      dmem_ack,
  input  logic                      dmem_err,
  output logic                      wb_stall,
  output logic [XLEN-1:0]           wb_pc,
  output logic [XLEN-1:0]           wb_instr,
  output logic                      wb_bubble,
  output logic [EXCEPTION_SIZE-1:0] wb_exception,
  output logic [XLEN-1:0]           wb_badaddr,
  output logic                      wb_we,
  output logic [4:0]                wb_dst,
  output logic [XLEN-1:0]           wb_r
);

  localparam int            CW        = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_COUNT = CW'(DMEM_TIMEOUT);
  localparam logic [XLEN-1:0] NOP     = 'h13;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [XLEN-1:0]           pc_q, pc_d;
  logic [XLEN-1:0]           instr_q, instr_d;
  logic                      bubble_q, bubble_d;
  logic [EXCEPTION_SIZE-1:0] exc_q, exc_d;
  logic [XLEN-1:0]           badaddr_q, badaddr_d;
  logic                      we_q, we_d;
  logic [4:0]                dst_q, dst_d;
  logic [XLEN-1:0]           r_q, r_d;

  logic [4:0]                w_opcode;
  logic [2:0]                w_funct3;
  logic [4:0]                w_rd;
  logic                      w_is_load;
  logic                      w_is_store;
  logic                      w_has_rd;
  logic                      w_pending;
  logic                      w_timeout;
  logic                      w_stall;
  logic                      w_fault;
  logic [EXCEPTION_SIZE-1:0] w_fault_vec;
  logic [EXCEPTION_SIZE-1:0] w_exc_next;
  logic [XLEN-1:0]           w_shifted;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [XLEN-1:0]           w_load_data;

  assign w_opcode   = mem_instr[6:2];
  assign w_funct3   = mem_instr[14:12];
  assign w_rd       = mem_instr[11:7];
  assign w_is_load  = (w_opcode == 5'b00000);
  assign w_is_store = (w_opcode == 5'b01000);

  always_comb begin
    w_has_rd = 1'b0;
    case (w_opcode)
      5'b01100, 5'b00100, 5'b01101, 5'b00101,
      5'b11011, 5'b11001, 5'b00000: w_has_rd = 1'b1;
      5'b11100:                     w_has_rd = (w_funct3 != 3'b000);
      default:                      w_has_rd = 1'b0;
    endcase
  end

  // A pending exception in WB flushes the incoming access, so it never waits.
  assign w_pending = (w_is_load | w_is_store) & ~mem_bubble
                   & ~|mem_exception & ~|exc_q;
  assign w_timeout = (state_q == WAIT) & (count_q == TMO_COUNT);
  assign w_stall   = w_pending & ~dmem_ack & ~dmem_err & ~w_timeout;
  assign w_fault   = w_pending & (dmem_err | (w_timeout & ~dmem_ack));

  always_comb begin
    w_fault_vec = '0;
    if (w_fault) begin
      if (w_is_load) w_fault_vec[CAUSE_LOAD_ACCESS_FAULT]  = 1'b1;
      else           w_fault_vec[CAUSE_STORE_ACCESS_FAULT] = 1'b1;
    end
  end

  assign w_exc_next = mem_exception | w_fault_vec;

  assign w_shifted = dmem_q >> {mem_memadr[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = mem_memadr[1] ? dmem_q[31:16] : dmem_q[15:0];

  always_comb begin
    case (w_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = dmem_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (w_stall) state_d = WAIT;
      end
      WAIT: begin
        if (w_stall) begin
          count_d = count_q + CW'(1);
        end else begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    bubble_d  = bubble_q;
    exc_d     = exc_q;
    badaddr_d = badaddr_q;
    we_d      = we_q;
    dst_d     = dst_q;
    r_d       = r_q;
    if (w_stall) begin
      bubble_d = 1'b1;
      we_d     = 1'b0;
    end else begin
      pc_d     = mem_pc;
      instr_d  = mem_instr;
      bubble_d = mem_bubble;
      dst_d    = w_rd;
      r_d      = w_is_load ? w_load_data : mem_r;
      exc_d    = w_exc_next;
      we_d     = ~mem_bubble & w_has_rd & (w_rd != 5'd0) & ~|w_exc_next;
      if (w_fault) badaddr_d = mem_memadr;
      // One-cycle flush pulse: the instruction behind a trap is squashed.
      if (|exc_q) begin
        exc_d    = '0;
        we_d     = 1'b0;
        bubble_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pc_q      <= PC_INIT;
      instr_q   <= NOP;
      bubble_q  <= 1'b1;
      exc_q     <= '0;
      badaddr_q <= '0;
      we_q      <= 1'b0;
      dst_q     <= 5'd0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      bubble_q  <= bubble_d;
      exc_q     <= exc_d;
      badaddr_q <= badaddr_d;
      we_q      <= we_d;
      dst_q     <= dst_d;
      r_q       <= r_d;
    end
  end

  assign wb_stall     = w_stall;
  assign wb_pc        = pc_q;
  assign wb_instr     = instr_q;
  assign wb_bubble    = bubble_q;
  assign wb_exception = exc_q;
  assign wb_badaddr   = badaddr_q;
  assign wb_we        = we_q;
  assign wb_dst       = dst_q;
  assign wb_r         = r_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_wb.sv
// ============================================================================
// Module   : tb_riscv_wb
// Purpose  : Directed self-checking bench for the riscv_wb write-back stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_wb;
  import riscv_pkg::*;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [31:0]               mem_pc;
  logic [31:0]               mem_instr;
  logic                      mem_bubble;
  logic [EXCEPTION_SIZE-1:0] mem_exception;
  logic [31:0]               mem_r;
  logic [31:0]               mem_memadr;
  logic [31:0]               dmem_q;
  logic                      dmem_ack;
  logic                      dmem_err;
  logic                      wb_stall;
  logic [31:0]               wb_pc;
  logic [31:0]               wb_instr;
  logic                      wb_bubble;
  logic [EXCEPTION_SIZE-1:0] wb_exception;
  logic [31:0]               wb_badaddr;
  logic                      wb_we;
  logic [4:0]                wb_dst;
  logic [31:0]               wb_r;

  int vectors    = 0;
  int miscompares = 0;

  riscv_wb #(
    .XLEN         (32),
    .PC_INIT      (32'h200),
    .DMEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .mem_pc        (mem_pc),
    .mem_instr     (mem_instr),
    .mem_bubble    (mem_bubble),
    .mem_exception (mem_exception),
    .mem_r         (mem_r),
    .mem_memadr    (mem_memadr),
    .dmem_q        (dmem_q),
    .dmem_ack      (dmem_ack),
    .dmem_err      (dmem_err),
    .wb_stall      (wb_stall),
    .wb_pc         (wb_pc),
    .wb_instr      (wb_instr),
    .wb_bubble     (wb_bubble),
    .wb_exception  (wb_exception),
    .wb_badaddr    (wb_badaddr),
    .wb_we         (wb_we),
    .wb_dst        (wb_dst),
    .wb_r          (wb_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_pc        = 32'h0;
    mem_instr     = 32'h13;
    mem_bubble    = 1'b1;
    mem_exception = '0;
    mem_r         = 32'h0;
    mem_memadr    = 32'h0;
    dmem_q        = 32'h0;
    dmem_ack      = 1'b0;
    dmem_err      = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] r, input logic [31:0] adr);
    mem_pc     = pc;
    mem_instr  = instr;
    mem_bubble = 1'b0;
    mem_r      = r;
    mem_memadr = adr;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_pc"},      wb_pc,        32'h200);
    chk({pfx, "_instr"},   wb_instr,     32'h13);
    chk({pfx, "_bubble"},  32'(wb_bubble), 32'd1);
    chk({pfx, "_exc"},     32'(wb_exception), 32'd0);
    chk({pfx, "_badaddr"}, wb_badaddr,   32'd0);
    chk({pfx, "_we"},      32'(wb_we),   32'd0);
    chk({pfx, "_dst"},     32'(wb_dst),  32'd0);
    chk({pfx, "_r"},       wb_r,         32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    drive_idle();
    #12;
    chk_reset("rst");
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // ADDI x5, mem_r passthrough
    drive(32'h100, 32'h0000_0293, 32'h1234, 32'h0);
    #1 chk("addi_stall", 32'(wb_stall), 32'd0);
    tick();
    chk("addi_we", 32'(wb_we), 32'd1);
    chk("addi_dst", 32'(wb_dst), 32'd5);
    chk("addi_r", wb_r, 32'h1234);
    chk("addi_bubble", 32'(wb_bubble), 32'd0);
    chk("addi_pc", wb_pc, 32'h100);

    // LB / LBU lane 3 with same-cycle ack
    drive(32'h104, 32'h0000_0303, 32'h0, 32'h1003);
    dmem_q   = 32'h80FF_0000;
    dmem_ack = 1'b1;
    #1 chk("lb_stall", 32'(wb_stall), 32'd0);
    tick();
    chk("lb_r", wb_r, 32'hFFFF_FF80);
    chk("lb_we", 32'(wb_we), 32'd1);
    chk("lb_dst", 32'(wb_dst), 32'd6);
    drive(32'h108, 32'h0000_4303, 32'h0, 32'h1003);
    tick();
    chk("lbu_r", wb_r, 32'h0000_0080);

    // LW acknowledged after three stall cycles
    drive(32'h10C, 32'h0000_2383, 32'h0, 32'h2000);
    dmem_q   = 32'hCAFE_BABE;
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lw_stall_hi", 32'(wb_stall), 32'd1);
      tick();
      chk("lw_stall_bubble", 32'(wb_bubble), 32'd1);
      chk("lw_stall_we", 32'(wb_we), 32'd0);
      chk("lw_stall_pc_hold", wb_pc, 32'h108);
    end
    dmem_ack = 1'b1;
    #1 chk("lw_stall_lo", 32'(wb_stall), 32'd0);
    tick();
    chk("lw_r", wb_r, 32'hCAFE_BABE);
    chk("lw_we", 32'(wb_we), 32'd1);
    chk("lw_dst", 32'(wb_dst), 32'd7);
    chk("lw_bubble", 32'(wb_bubble), 32'd0);
    chk("lw_pc", wb_pc, 32'h10C);

    // SW with bus error on the second cycle
    dmem_ack = 1'b0;
    drive(32'h110, 32'h0000_2023, 32'h0, 32'h3004);
    #1 chk("sw_stall_hi", 32'(wb_stall), 32'd1);
    tick();
    dmem_err = 1'b1;
    #1 chk("sw_stall_lo", 32'(wb_stall), 32'd0);
    tick();
    chk("sw_exc", 32'(wb_exception), 32'h80);
    chk("sw_badaddr", wb_badaddr, 32'h3004);
    chk("sw_we", 32'(wb_we), 32'd0);
    dmem_err = 1'b0;
    drive(32'h114, 32'h0000_0293, 32'h5555, 32'h0);
    tick();
    chk("flush_exc", 32'(wb_exception), 32'd0);
    chk("flush_we", 32'(wb_we), 32'd0);
    chk("flush_bubble", 32'(wb_bubble), 32'd1);

    // LW timeout: one IDLE cycle plus DMEM_TIMEOUT waiting cycles
    drive(32'h118, 32'h0000_2383, 32'h0, 32'h4008);
    for (int i = 0; i < 5; i++) begin
      #1 chk("tmo_stall_hi", 32'(wb_stall), 32'd1);
      tick();
    end
    #1 chk("tmo_stall_lo", 32'(wb_stall), 32'd0);
    tick();
    chk("tmo_exc", 32'(wb_exception), 32'h20);
    chk("tmo_badaddr", wb_badaddr, 32'h4008);
    chk("tmo_we", 32'(wb_we), 32'd0);
    drive_idle();
    tick();
    chk("tmo_clear", 32'(wb_exception), 32'd0);

    // LW acknowledged exactly in the timeout cycle
    drive(32'h11C, 32'h0000_2383, 32'h0, 32'h400C);
    dmem_q = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      #1 chk("tack_stall_hi", 32'(wb_stall), 32'd1);
      tick();
    end
    dmem_ack = 1'b1;
    #1 chk("tack_stall_lo", 32'(wb_stall), 32'd0);
    tick();
    chk("tack_exc", 32'(wb_exception), 32'd0);
    chk("tack_we", 32'(wb_we), 32'd1);
    chk("tack_r", wb_r, 32'h1234_5678);
    dmem_ack = 1'b0;

    // write to x0, then bubbled instruction
    drive(32'h120, 32'h0000_0013, 32'h7777, 32'h0);
    tick();
    chk("x0_we", 32'(wb_we), 32'd0);
    chk("x0_bubble", 32'(wb_bubble), 32'd0);
    drive(32'h124, 32'h0000_0293, 32'h8888, 32'h0);
    mem_bubble = 1'b1;
    tick();
    chk("bub_we", 32'(wb_we), 32'd0);
    chk("bub_bubble", 32'(wb_bubble), 32'd1);

    // reset asserted while waiting on a load
    drive(32'h128, 32'h0000_2383, 32'h0, 32'h5000);
    #1 chk("rwait_stall", 32'(wb_stall), 32'd1);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    chk_reset("rwait");
    drive_idle();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_rst_we", 32'(wb_we), 32'd0);
    chk("post_rst_stall", 32'(wb_stall), 32'd0);
    chk("post_rst_exc", 32'(wb_exception), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_wb.md
Name: riscv_wb

Overview:
- Write-back stage.
- Consumes the MEM-stage pipeline register (pc, instr, bubble, exception, ALU result, data address) and the data-memory response.
- Aligns and sign-extends load data, drives the register-file write port, and raises access-fault exceptions.
- Generates wb_stall and wb_exception back to the MEM stage, holding it while a load or store awaits its bus response.

Parameters:
- XLEN, 32, data/address width.
- PC_INIT, 'h200, reset value of wb_pc.
- DMEM_TIMEOUT, 64, cycles to wait for dmem_ack/dmem_err before declaring an access fault (>=1).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- mem_pc  in  XLEN  MEM-stage PC
- mem_instr  in  XLEN  MEM-stage instruction
- mem_bubble  in  1  MEM stage holds no valid instruction
- mem_exception  in  EXCEPTION_SIZE  MEM-stage exception vector (riscv_pkg)
- mem_r  in  XLEN  ALU/CSR result
- mem_memadr  in  XLEN  data-memory byte address
- dmem_q  in  XLEN  load read data, valid with dmem_ack
- dmem_ack  in  1  data access completed
- dmem_err  in  1  data access bus error
- wb_stall  out  1  hold MEM stage (combinational)
- wb_pc  out  XLEN  WB PC
- wb_instr  out  XLEN  WB instruction
- wb_bubble  out  1  WB holds no valid instruction
- wb_exception  out  EXCEPTION_SIZE  WB exception vector
- wb_badaddr  out  XLEN  faulting data address
- wb_we  out  1  register-file write enable
- wb_dst  out  5  destination register
- wb_r  out  XLEN  write-back data

Behaviour:
- Reset values: wb_pc=PC_INIT, wb_instr=32'h00000013, wb_bubble=1, wb_exception=0, wb_badaddr=0, wb_we=0, wb_dst=0, wb_r=0, FSM=IDLE, timeout count=0.
- Decode from mem_instr:
  - is_load: opcode[6:2]=5'b00000.
  - is_store: opcode[6:2]=5'b01000.
  - has_rd: OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, SYSTEM with funct3!=0.
  - rd=instr[11:7].
- pending = (is_load|is_store) & !mem_bubble & ~|mem_exception & ~|wb_exception.
- timeout = (state==WAIT) & (count==DMEM_TIMEOUT).
- wb_stall = pending & !dmem_ack & !dmem_err & !timeout. A response in the same cycle as the request gives zero stall.
- FSM:
  - IDLE->WAIT when wb_stall. Count cleared in IDLE.
  - In WAIT, count increments each stalled cycle.
  - WAIT->IDLE on dmem_ack, dmem_err or timeout.
- Response priority: dmem_err > dmem_ack > timeout. An ack in the timeout cycle is treated as success.
- Fault = pending & (dmem_err | (timeout & !dmem_ack)). Sets exception bit CAUSE_LOAD_ACCESS_FAULT (5) for a load or CAUSE_STORE_ACCESS_FAULT (7) for a store, ORed into the captured mem_exception. wb_badaddr <= mem_memadr on a fault.
- Capture, on each posedge with !wb_stall:
  - wb_pc, wb_instr and wb_bubble follow the MEM-stage values.
  - wb_dst <= rd.
  - wb_r <= load-aligned data if is_load, else mem_r.
- Stall bubble: on each posedge with wb_stall, wb_bubble<=1 and wb_we<=0. wb_pc, wb_instr, wb_r and wb_dst hold.
- wb_we <= !mem_bubble & has_rd & rd!=0 & no exception (incoming or fault) & !wb_stall.
- wb_exception:
  - registered; if currently nonzero, cleared to 0 next cycle (one-cycle flush pulse), with wb_we=0 and wb_bubble=1 that cycle;
  - else on !wb_stall <= mem_exception | fault bits.
- Load alignment on dmem_q, lane by mem_memadr[1:0]:
  - funct3 000 LB / 100 LBU: byte at lane*8, sign- or zero-extended.
  - 001 LH / 101 LHU: halfword at mem_memadr[1]*16, sign- or zero-extended.
  - 010 LW and any other funct3: full word.
- Reset asserted mid-WAIT returns the FSM to IDLE and all outputs to reset values; no pending write completes.

Test Plan:
- ADDI x5 (rd=5), mem_r=32'h1234, no stall -> next cycle wb_we=1, wb_dst=5, wb_r=32'h1234, wb_bubble=0.
- LB, mem_memadr[1:0]=3, dmem_q=32'h80FF_0000, dmem_ack same cycle -> wb_stall=0, wb_r=32'hFFFF_FF80; LBU at the same address -> 32'h0000_0080.
- LW with dmem_ack after 3 cycles -> wb_stall high exactly 3 cycles, wb_bubble=1 and wb_we=0 during the stall, then wb_r=dmem_q, wb_we=1.
- SW with dmem_err on cycle 2 -> wb_exception bit 7 set for one cycle, wb_badaddr=mem_memadr, wb_we=0, then wb_exception=0.
- LW with no response, DMEM_TIMEOUT=4 -> stall ends after timeout, bit 5 set; repeat with ack in the timeout cycle -> no exception.
- Write to x0, bubble input, and rstn pulse during WAIT -> wb_we stays 0; after reset all outputs equal reset values.
